// File: rtl/alu_pipe.sv
// Pipelined ALU with carry-in, N/V/Z/C flags, optional 6502-style BCD add/sub and a
// single valid/ready output register stage. Decimal ops take one extra cycle for correction.
module alu_pipe #(
  parameter int unsigned WIDTH      = 16,
  parameter bit          DECIMAL_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic [3:0]       alu_op_i,
  input  logic             carry_i,
  input  logic             dec_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] res_o,
  output logic [3:0]       flags_o
);

  localparam logic [3:0] OpPassA = 4'd0;
  localparam logic [3:0] OpPassB = 4'd1;
  localparam logic [3:0] OpAdd   = 4'd2;
  localparam logic [3:0] OpAddZp = 4'd3;
  localparam logic [3:0] OpSub   = 4'd4;
  localparam logic [3:0] OpOr    = 4'd5;
  localparam logic [3:0] OpXor   = 4'd6;
  localparam logic [3:0] OpAnd   = 4'd7;
  localparam logic [3:0] OpAsl   = 4'd8;
  localparam logic [3:0] OpLsr   = 4'd9;
  localparam logic [3:0] OpRol   = 4'd10;
  localparam logic [3:0] OpRor   = 4'd11;
  localparam logic [3:0] OpCmp   = 4'd12;

  typedef enum logic [0:0] {StIdle, StDecFix} state_e;

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flags_q, flags_d;

  logic [4:0] dec_lo_q;
  logic [3:0] dec_a_hi_q, dec_b_hi_q;
  logic       dec_sub_q, dec_v_q;

  logic slot_free, accept, is_dec;

  assign slot_free   = !valid_q || out_ready_i;
  assign in_ready_o  = !rst_i && (state_q == StIdle) && slot_free;
  assign accept      = in_valid_i && in_ready_o;
  assign is_dec      = DECIMAL_EN && dec_i && (alu_op_i == OpAdd || alu_op_i == OpSub);
  assign out_valid_o = valid_q;
  assign res_o       = res_q;
  assign flags_o     = flags_q;

  // Shared adder: SUB and CMP add the inverted B operand; CMP forces carry-in.
  logic [WIDTH-1:0] b_eff;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic             add_v;
  logic [8:0]       zp_sum;
  logic             zp_v;
  logic [7:0]       byte_bin;
  logic             byte_v;

  always_comb begin
    b_eff    = (alu_op_i == OpSub || alu_op_i == OpCmp) ? ~op_b_i : op_b_i;
    add_cin  = (alu_op_i == OpCmp) ? 1'b1 : carry_i;
    add_sum  = {1'b0, op_a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, add_cin};
    add_v    = (op_a_i[WIDTH-1] == b_eff[WIDTH-1]) && (add_sum[WIDTH-1] != op_a_i[WIDTH-1]);
    zp_sum   = {1'b0, op_a_i[7:0]} + {1'b0, op_b_i[7:0]};
    zp_v     = (op_a_i[7] == op_b_i[7]) && (zp_sum[7] != op_a_i[7]);
    byte_bin = op_a_i[7:0] + b_eff[7:0] + {7'b0, carry_i};
    byte_v   = (op_a_i[7] == b_eff[7]) && (byte_bin[7] != op_a_i[7]);
  end

  logic [WIDTH-1:0] bin_res, flag_src;
  logic             bin_c, bin_v, narrow, op_legal;
  logic [3:0]       bin_flags;

  always_comb begin
    bin_res  = '0;
    flag_src = '0;
    bin_c    = carry_i;
    bin_v    = 1'b0;
    narrow   = 1'b0;
    op_legal = 1'b1;
    case (alu_op_i)
      OpPassA: bin_res = op_a_i;
      OpPassB: bin_res = op_b_i;
      OpAdd, OpSub: begin
        bin_res = add_sum[WIDTH-1:0];
        bin_c   = add_sum[WIDTH];
        bin_v   = add_v;
      end
      OpAddZp: begin
        bin_res = {{(WIDTH-8){1'b0}}, zp_sum[7:0]};
        bin_c   = zp_sum[8];
        bin_v   = zp_v;
        narrow  = 1'b1;
      end
      OpOr:  bin_res = op_a_i | op_b_i;
      OpXor: bin_res = op_a_i ^ op_b_i;
      OpAnd: bin_res = op_a_i & op_b_i;
      OpAsl: begin
        bin_res = {op_a_i[WIDTH-2:0], 1'b0};
        bin_c   = op_a_i[WIDTH-1];
      end
      OpLsr: begin
        bin_res = {1'b0, op_a_i[WIDTH-1:1]};
        bin_c   = op_a_i[0];
      end
      OpRol: begin
        bin_res = {op_a_i[WIDTH-2:0], carry_i};
        bin_c   = op_a_i[WIDTH-1];
      end
      OpRor: begin
        bin_res = {carry_i, op_a_i[WIDTH-1:1]};
        bin_c   = op_a_i[0];
      end
      OpCmp: begin
        bin_res = op_a_i;
        bin_c   = add_sum[WIDTH];
      end
      default: op_legal = 1'b0;
    endcase
    flag_src = (alu_op_i == OpCmp) ? add_sum[WIDTH-1:0] : bin_res;
    if (!op_legal) begin
      bin_flags = 4'b0;
    end else if (narrow) begin
      bin_flags = {flag_src[7], bin_v, flag_src[7:0] == 8'd0, bin_c};
    end else begin
      bin_flags = {flag_src[WIDTH-1], bin_v, flag_src == '0, bin_c};
    end
  end

  // BCD correction on the latched nibble partial sums (B already inverted for SUB).
  logic       lo_c, hi_c;
  logic [3:0] lo_fix, hi_fix;
  logic [4:0] hi_sum;
  logic [7:0] dec_byte;

  always_comb begin
    lo_c     = dec_sub_q ? dec_lo_q[4] : (dec_lo_q > 5'd9);
    if (dec_sub_q) lo_fix = lo_c ? dec_lo_q[3:0] : dec_lo_q[3:0] - 4'd6;
    else           lo_fix = lo_c ? dec_lo_q[3:0] + 4'd6 : dec_lo_q[3:0];
    hi_sum   = {1'b0, dec_a_hi_q} + {1'b0, dec_b_hi_q} + {4'b0, lo_c};
    hi_c     = dec_sub_q ? hi_sum[4] : (hi_sum > 5'd9);
    if (dec_sub_q) hi_fix = hi_c ? hi_sum[3:0] : hi_sum[3:0] - 4'd6;
    else           hi_fix = hi_c ? hi_sum[3:0] + 4'd6 : hi_sum[3:0];
    dec_byte = {hi_fix, lo_fix};
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q && !out_ready_i;
    res_d   = res_q;
    flags_d = flags_q;
    unique case (state_q)
      StIdle: begin
        if (accept && is_dec) begin
          state_d = StDecFix;
        end else if (accept) begin
          valid_d = 1'b1;
          res_d   = bin_res;
          flags_d = bin_flags;
        end
      end
      StDecFix: begin
        if (slot_free) begin
          state_d = StIdle;
          valid_d = 1'b1;
          res_d   = {{(WIDTH-8){1'b0}}, dec_byte};
          flags_d = {dec_byte[7], dec_v_q, dec_byte == 8'd0, hi_c};
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept && is_dec) begin
      dec_lo_q   <= {1'b0, op_a_i[3:0]} + {1'b0, b_eff[3:0]} + {4'b0, carry_i};
      dec_a_hi_q <= op_a_i[7:4];
      dec_b_hi_q <= b_eff[7:4];
      dec_sub_q  <= (alu_op_i == OpSub);
      dec_v_q    <= byte_v;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Randomized and directed bench for alu_pipe (WIDTH=16, decimal enabled) against an
// integer-arithmetic reference model with an in-order result scoreboard.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, carry, dec, out_valid, out_ready;
  logic [15:0] op_a, op_b, res;
  logic [3:0]  alu_op, flags;

  int n_checks = 0;
  int n_fail   = 0;
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(16), .DECIMAL_EN(1'b1)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .op_a_i     (op_a),
    .op_b_i     (op_b),
    .alu_op_i   (alu_op),
    .carry_i    (carry),
    .dec_i      (dec),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .res_o      (res),
    .flags_o    (flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {res[15:0], N, V, Z, C}.
  function automatic logic [19:0] model(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic cin, input logic d);
    int ai, bi, ci, sa, sb, s, r, fs;
    bit n, v, z, c, narrow;
    logic [15:0] rr;
    ai = a; bi = b; ci = cin;
    sa = (ai >= 32768) ? ai - 65536 : ai;
    sb = (bi >= 32768) ? bi - 65536 : bi;
    s = 0; r = 0; v = 0; c = cin; narrow = 0;
    if (d && (op == 2 || op == 4)) begin
      int a8, b8, s8a, s8b, lo, hi, bw, cy;
      a8 = ai & 255; b8 = bi & 255;
      s8a = (a8 >= 128) ? a8 - 256 : a8;
      s8b = (b8 >= 128) ? b8 - 256 : b8;
      if (op == 2) begin
        s  = s8a + s8b + ci;
        lo = (a8 & 15) + (b8 & 15) + ci;
        cy = 0;
        if (lo > 9) begin lo += 6; cy = 1; end
        hi = (a8 >> 4) + (b8 >> 4) + cy;
        c  = 0;
        if (hi > 9) begin hi += 6; c = 1; end
      end else begin
        s  = s8a - s8b - (1 - ci);
        lo = (a8 & 15) - (b8 & 15) - (1 - ci);
        bw = (lo < 0) ? 1 : 0;
        if (bw != 0) lo -= 6;
        hi = (a8 >> 4) - (b8 >> 4) - bw;
        c  = (hi >= 0);
        if (hi < 0) hi -= 6;
      end
      v  = (s > 127 || s < -128);
      r  = ((hi & 15) << 4) | (lo & 15);
      rr = r[15:0];
      return {rr, rr[7], v, rr[7:0] == 8'd0, c};
    end
    case (op)
      0: r = ai;
      1: r = bi;
      2: begin
        s = ai + bi + ci; r = s & 16'hFFFF; c = (s > 16'hFFFF);
        s = sa + sb + ci; v = (s > 32767 || s < -32768);
      end
      3: begin
        s = (ai & 255) + (bi & 255); r = s & 255; c = (s > 255); narrow = 1;
        s = (((ai & 255) >= 128) ? (ai & 255) - 256 : (ai & 255))
          + (((bi & 255) >= 128) ? (bi & 255) - 256 : (bi & 255));
        v = (s > 127 || s < -128);
      end
      4: begin
        s = ai - bi - (1 - ci); r = s & 16'hFFFF; c = (s >= 0);
        s = sa - sb - (1 - ci); v = (s > 32767 || s < -32768);
      end
      5: r = ai | bi;
      6: r = ai ^ bi;
      7: r = ai & bi;
      8: begin r = (ai << 1) & 16'hFFFF; c = ((ai >> 15) & 1) != 0; end
      9: begin r = ai >> 1; c = (ai & 1) != 0; end
      10: begin r = ((ai << 1) | ci) & 16'hFFFF; c = ((ai >> 15) & 1) != 0; end
      11: begin r = (ai >> 1) | (ci << 15); c = (ai & 1) != 0; end
      12: begin r = ai; s = ai - bi; c = (s >= 0); end
      default: return 20'h0;
    endcase
    fs = (op == 12) ? (s & 16'hFFFF) : r;
    n  = narrow ? (((fs >> 7) & 1) != 0) : (((fs >> 15) & 1) != 0);
    z  = (fs == 0);
    rr = r[15:0];
    return {rr, n, v, z, c};
  endfunction

  // One cycle starting and ending at a negedge; scoreboards consume and accept.
  task automatic step();
    logic [19:0] e;
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_result", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("sb_res", {16'h0, res}, {16'h0, e[19:4]});
        check("sb_flags", {28'h0, flags}, {28'h0, e[3:0]});
      end
    end
    if (in_valid && in_ready) exp_q.push_back(model(alu_op, op_a, op_b, carry, dec));
    @(posedge clk);
    if (rst) exp_q.delete();
    @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic d);
    alu_op = op; op_a = a; op_b = b; carry = cin; dec = d; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  logic [19:0] held;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = '0; op_a = '0; op_b = '0; carry = 1'b0; dec = 1'b0;
    @(negedge clk);
    step();
    check("rst_in_ready", {31'h0, in_ready}, 32'd0);
    check("rst_valid", {31'h0, out_valid}, 32'd0);
    check("rst_res", {16'h0, res}, 32'd0);
    check("rst_flags", {28'h0, flags}, 32'd0);
    rst = 1'b0;
    step();

    issue(4'd2, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    check("add_valid", {31'h0, out_valid}, 32'd1);
    check("add_res", {16'h0, res}, 32'h8000);
    check("add_flags", {28'h0, flags}, 32'hC);
    issue(4'd4, 16'h0005, 16'h0005, 1'b1, 1'b0);
    check("sub_eq_res", {16'h0, res}, 32'h0000);
    check("sub_eq_flags", {28'h0, flags}, 32'h3);
    issue(4'd4, 16'h0003, 16'h0005, 1'b1, 1'b0);
    check("sub_lt_res", {16'h0, res}, 32'hFFFE);
    check("sub_lt_flags", {28'h0, flags}, 32'h8);
    issue(4'd12, 16'h0003, 16'h0005, 1'b1, 1'b0);
    check("cmp_res", {16'h0, res}, 32'h0003);
    check("cmp_flags", {28'h0, flags}, 32'h8);
    issue(4'd3, 16'h12F0, 16'h0020, 1'b1, 1'b0);
    check("zp_res", {16'h0, res}, 32'h0010);
    check("zp_flags", {28'h0, flags}, 32'h1);
    issue(4'd11, 16'h0001, 16'h0000, 1'b1, 1'b0);
    check("ror_res", {16'h0, res}, 32'h8000);
    check("ror_flags", {28'h0, flags}, 32'h9);

    issue(4'd2, 16'h0058, 16'h0046, 1'b0, 1'b1);
    check("dec_fix_ready", {31'h0, in_ready}, 32'd0);
    check("dec_fix_valid", {31'h0, out_valid}, 32'd0);
    step();
    check("dadd_valid", {31'h0, out_valid}, 32'd1);
    check("dadd_res", {16'h0, res}, 32'h0004);
    check("dadd_c", {31'h0, flags[0]}, 32'd1);
    check("dadd_ready_back", {31'h0, in_ready}, 32'd1);
    issue(4'd4, 16'h0012, 16'h0021, 1'b1, 1'b1);
    step();
    check("dsub_res", {16'h0, res}, 32'h0091);
    check("dsub_c", {31'h0, flags[0]}, 32'd0);
    step();

    // Backpressure: hold a result, then release into back-to-back ops.
    out_ready = 1'b0;
    held = model(4'd6, 16'hA5A5, 16'h0FF0, 1'b1, 1'b0);
    issue(4'd6, 16'hA5A5, 16'h0FF0, 1'b1, 1'b0);
    alu_op = 4'd5; op_a = 16'h1234; op_b = 16'h4321; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_ready", {31'h0, in_ready}, 32'd0);
      check("bp_res", {16'h0, res}, {16'h0, held[19:4]});
      check("bp_flags", {28'h0, flags}, {28'h0, held[3:0]});
    end
    out_ready = 1'b1;
    issue(4'd8, 16'hC001, 16'h0, 1'b0, 1'b0);
    held = model(4'd8, 16'hC001, 16'h0, 1'b0, 1'b0);
    check("b2b_0", {12'h0, res, flags}, {12'h0, held});
    issue(4'd9, 16'h8003, 16'h0, 1'b0, 1'b0);
    held = model(4'd9, 16'h8003, 16'h0, 1'b0, 1'b0);
    check("b2b_1", {12'h0, res, flags}, {12'h0, held});
    issue(4'd10, 16'h8000, 16'h0, 1'b1, 1'b0);
    held = model(4'd10, 16'h8000, 16'h0, 1'b1, 1'b0);
    check("b2b_2", {12'h0, res, flags}, {12'h0, held});

    // Reset while the decimal fix is pending.
    issue(4'd2, 16'h0099, 16'h0001, 1'b0, 1'b1);
    rst = 1'b1;
    step();
    check("rst_dec_valid", {31'h0, out_valid}, 32'd0);
    check("rst_dec_res", {16'h0, res}, 32'd0);
    check("rst_dec_flags", {28'h0, flags}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("no_stale", {31'h0, out_valid}, 32'd0);
    end

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      alu_op    = 4'($urandom_range(0, 15));
      op_a      = 16'($urandom);
      op_b      = 16'($urandom);
      carry     = 1'($urandom);
      dec       = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("drain_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
